// File: rtl/ch0re_decoder_pkg.sv
// Shared decode types for the ch0re decoder: opcode constants, output enums and the registered decode bundle.
// Latency: none (types only). Backpressure: none.
// Backpressure behaviour: not applicable.
package ch0re_types;

    localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
    localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
    localparam logic [4:0] OPCODE_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPCODE_STORE    = 5'b01000;
    localparam logic [4:0] OPCODE_OP       = 5'b01100;
    localparam logic [4:0] OPCODE_LUI      = 5'b01101;
    localparam logic [4:0] OPCODE_OP32     = 5'b01110;
    localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
    localparam logic [4:0] OPCODE_JALR     = 5'b11001;
    localparam logic [4:0] OPCODE_JAL      = 5'b11011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} iformat_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
        ALU_SEQ, ALU_SNE, ALU_SGE, ALU_SGEU
    } alu_op_e;

    typedef enum logic [1:0] {MUX1_REG, MUX1_PC, MUX1_IMM} alu_mux1_sel_e;
    typedef enum logic {MUX2_REG, MUX2_IMM} alu_mux2_sel_e;

    // Order matches the LOAD funct3 encoding so funct3 can be cast directly.
    typedef enum logic [2:0] {
        DT_BYTE, DT_HALF, DT_WORD, DT_DWORD, DT_UBYTE, DT_UHALF, DT_UWORD
    } data_type_e;

    typedef enum logic [1:0] {SHAMT_NONE, SHAMT_6, SHAMT_5} shamt_e;

    typedef struct packed {
        logic          illegal;
        logic [4:0]    rf_raddr1;
        logic [4:0]    rf_raddr2;
        logic [4:0]    rf_waddr;
        logic [63:0]   imm;
        iformat_e      fmt;
        alu_op_e       alu_op;
        alu_mux1_sel_e mux1_sel;
        alu_mux2_sel_e mux2_sel;
        data_type_e    data_type;
    } dec_t;

    localparam dec_t DEC_NOP = '{
        illegal:   1'b0,
        rf_raddr1: 5'd0,
        rf_raddr2: 5'd0,
        rf_waddr:  5'd0,
        imm:       64'd0,
        fmt:       FMT_I,
        alu_op:    ALU_ADD,
        mux1_sel:  MUX1_REG,
        mux2_sel:  MUX2_IMM,
        data_type: DT_DWORD
    };

endpackage

// File: rtl/ch0re_decoder_imm_gen.sv
// Immediate generator: builds the sign-extended 64-bit immediate from instruction bits and format.
// Latency: combinational.
// Backpressure behaviour: none, pure function of its inputs.
module ch0re_imm_gen
    import ch0re_types::*;
(
    input  logic [31:7] i_instr,
    input  iformat_e    i_fmt,
    input  shamt_e      i_shamt,
    output logic [63:0] o_imm
);

    always_comb begin
        o_imm = 64'd0;
        case (i_fmt)
            FMT_I: o_imm = {{52{i_instr[31]}}, i_instr[31:20]};
            FMT_S: o_imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: o_imm = {{51{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: o_imm = {{32{i_instr[31]}}, i_instr[31:12], 12'd0};
            FMT_J: o_imm = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = 64'd0;
        endcase
        // Shift amounts replace the I immediate and are zero-extended.
        case (i_shamt)
            SHAMT_6: o_imm = {58'd0, i_instr[25:20]};
            SHAMT_5: o_imm = {59'd0, i_instr[24:20]};
            default: ;
        endcase
    end

endmodule

// File: rtl/ch0re_decoder.sv
// RV64I/RV32I instruction decoder with one output register; CH0RE_RV64_EN enables the RV64-only encodings.
// Latency: 1 cycle, one instruction per cycle.
// Backpressure behaviour: none, no handshake or stall; sync active-high reset loads the NOP decode.
module ch0re_decoder
    import ch0re_types::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [31:0]   i_instr,
    output logic          o_illegal_instr,
    output logic [4:0]    o_rf_raddr1,
    output logic [4:0]    o_rf_raddr2,
    output logic [4:0]    o_rf_waddr,
    output logic [63:0]   o_imm,
    output iformat_e      o_instr_format,
    output alu_op_e       o_alu_op,
    output alu_mux1_sel_e o_alu_mux1_sel,
    output alu_mux2_sel_e o_alu_mux2_sel,
    output data_type_e    o_data_type
);

`ifdef CH0RE_RV64_EN
    localparam logic RV64 = 1'b1;
`else
    localparam logic RV64 = 1'b0;
`endif

    logic [4:0]    opcode;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [6:0]    funct7;
    logic          illegal;
    iformat_e      fmt;
    alu_op_e       alu_op;
    alu_mux1_sel_e mux1;
    alu_mux2_sel_e mux2;
    data_type_e    dtype;
    shamt_e        shamt;
    logic [63:0]   imm;
    dec_t          dec_d;
    dec_t          dec_q;

    assign opcode = i_instr[6:2];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    always_comb begin
        illegal = (i_instr[1:0] != 2'b11);
        fmt     = FMT_I;
        alu_op  = ALU_ADD;
        mux1    = MUX1_REG;
        mux2    = MUX2_IMM;
        dtype   = DT_DWORD;
        shamt   = SHAMT_NONE;
        case (opcode)
            OPCODE_OP: begin
                fmt  = FMT_R;
                mux2 = MUX2_REG;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd0:    alu_op = ALU_ADD;
                        3'd1:    alu_op = ALU_SLL;
                        3'd2:    alu_op = ALU_SLT;
                        3'd3:    alu_op = ALU_SLTU;
                        3'd4:    alu_op = ALU_XOR;
                        3'd5:    alu_op = ALU_SRL;
                        3'd6:    alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPCODE_OP32: begin
                fmt  = FMT_R;
                mux2 = MUX2_REG;
                if (!RV64) illegal = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: alu_op = ALU_ADDW;
                    {7'h20, 3'd0}: alu_op = ALU_SUBW;
                    {7'h00, 3'd1}: alu_op = ALU_SLLW;
                    {7'h00, 3'd5}: alu_op = ALU_SRLW;
                    {7'h20, 3'd5}: alu_op = ALU_SRAW;
                    default:       illegal = 1'b1;
                endcase
            end
            OPCODE_OP_IMM: begin
                case (funct3)
                    3'd0: alu_op = ALU_ADD;
                    3'd2: alu_op = ALU_SLT;
                    3'd3: alu_op = ALU_SLTU;
                    3'd4: alu_op = ALU_XOR;
                    3'd6: alu_op = ALU_OR;
                    3'd7: alu_op = ALU_AND;
                    3'd1: begin
                        alu_op = ALU_SLL;
                        shamt  = SHAMT_6;
                        if (i_instr[31:26] != 6'h00) illegal = 1'b1;
                    end
                    default: begin
                        shamt = SHAMT_6;
                        if (i_instr[31:26] == 6'h10) begin
                            alu_op = ALU_SRA;
                        end else begin
                            alu_op = ALU_SRL;
                            if (i_instr[31:26] != 6'h00) illegal = 1'b1;
                        end
                    end
                endcase
                // RV32 shift amounts are only 5 bits wide.
                if (shamt == SHAMT_6 && !RV64 && i_instr[25]) illegal = 1'b1;
            end
            OPCODE_OP_IMM32: begin
                if (!RV64) illegal = 1'b1;
                case (funct3)
                    3'd0: alu_op = ALU_ADDW;
                    3'd1: begin
                        alu_op = ALU_SLLW;
                        shamt  = SHAMT_5;
                        if (funct7 != 7'h00) illegal = 1'b1;
                    end
                    3'd5: begin
                        shamt = SHAMT_5;
                        if (funct7 == 7'h20) begin
                            alu_op = ALU_SRAW;
                        end else begin
                            alu_op = ALU_SRLW;
                            if (funct7 != 7'h00) illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_LOAD: begin
                if (funct3 == 3'd7) begin
                    illegal = 1'b1;
                end else begin
                    dtype = data_type_e'(funct3);
                end
                if (!RV64 && (funct3 == 3'd3 || funct3 == 3'd6)) illegal = 1'b1;
            end
            OPCODE_STORE: begin
                fmt = FMT_S;
                if (funct3[2]) begin
                    illegal = 1'b1;
                end else begin
                    dtype = data_type_e'(funct3);
                end
                if (!RV64 && funct3 == 3'd3) illegal = 1'b1;
            end
            OPCODE_BRANCH: begin
                fmt  = FMT_B;
                mux2 = MUX2_REG;
                case (funct3)
                    3'd0:    alu_op = ALU_SEQ;
                    3'd1:    alu_op = ALU_SNE;
                    3'd4:    alu_op = ALU_SLT;
                    3'd5:    alu_op = ALU_SGE;
                    3'd6:    alu_op = ALU_SLTU;
                    3'd7:    alu_op = ALU_SGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_JAL: begin
                fmt  = FMT_J;
                mux1 = MUX1_PC;
            end
            OPCODE_JALR: begin
                if (funct3 != 3'd0) illegal = 1'b1;
            end
            OPCODE_LUI: begin
                fmt  = FMT_U;
                mux1 = MUX1_IMM;
            end
            OPCODE_AUIPC: begin
                fmt  = FMT_U;
                mux1 = MUX1_PC;
            end
            default: illegal = 1'b1;
        endcase
    end

    ch0re_imm_gen u_imm_gen (
        .i_instr (i_instr[31:7]),
        .i_fmt   (fmt),
        .i_shamt (shamt),
        .o_imm   (imm)
    );

    always_comb begin
        dec_d           = DEC_NOP;
        dec_d.illegal   = illegal;
        dec_d.imm       = imm;
        dec_d.fmt       = fmt;
        dec_d.alu_op    = alu_op;
        dec_d.mux1_sel  = mux1;
        dec_d.mux2_sel  = mux2;
        dec_d.data_type = dtype;
        dec_d.rf_raddr1 = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) ? rs1 : 5'd0;
        dec_d.rf_raddr2 = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? rs2 : 5'd0;
        // Suppressing rd on illegal encodings keeps the register file safe regardless of other fields.
        dec_d.rf_waddr  = (!illegal && (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J))
                          ? rd : 5'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dec_q <= DEC_NOP;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign o_illegal_instr = dec_q.illegal;
    assign o_rf_raddr1     = dec_q.rf_raddr1;
    assign o_rf_raddr2     = dec_q.rf_raddr2;
    assign o_rf_waddr      = dec_q.rf_waddr;
    assign o_imm           = dec_q.imm;
    assign o_instr_format  = dec_q.fmt;
    assign o_alu_op        = dec_q.alu_op;
    assign o_alu_mux1_sel  = dec_q.mux1_sel;
    assign o_alu_mux2_sel  = dec_q.mux2_sel;
    assign o_data_type     = dec_q.data_type;

endmodule

// File: tb/tb_ch0re_decoder.sv
// Randomised bench for ch0re_decoder against a table-driven reference decode; honours CH0RE_RV64_EN.
module tb_ch0re_decoder;
    import ch0re_types::*;

`ifdef CH0RE_RV64_EN
    localparam bit RV64 = 1'b1;
`else
    localparam bit RV64 = 1'b0;
`endif

    logic          i_clk;
    logic          i_rst;
    logic [31:0]   i_instr;
    logic          o_illegal_instr;
    logic [4:0]    o_rf_raddr1;
    logic [4:0]    o_rf_raddr2;
    logic [4:0]    o_rf_waddr;
    logic [63:0]   o_imm;
    iformat_e      o_instr_format;
    alu_op_e       o_alu_op;
    alu_mux1_sel_e o_alu_mux1_sel;
    alu_mux2_sel_e o_alu_mux2_sel;
    data_type_e    o_data_type;

    ch0re_decoder dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_instr         (i_instr),
        .o_illegal_instr (o_illegal_instr),
        .o_rf_raddr1     (o_rf_raddr1),
        .o_rf_raddr2     (o_rf_raddr2),
        .o_rf_waddr      (o_rf_waddr),
        .o_imm           (o_imm),
        .o_instr_format  (o_instr_format),
        .o_alu_op        (o_alu_op),
        .o_alu_mux1_sel  (o_alu_mux1_sel),
        .o_alu_mux2_sel  (o_alu_mux2_sel),
        .o_data_type     (o_data_type)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic          ill;
        logic [4:0]    ra1;
        logic [4:0]    ra2;
        logic [4:0]    wa;
        logic [63:0]   imm;
        iformat_e      fmt;
        alu_op_e       op;
        alu_mux1_sel_e m1;
        alu_mux2_sel_e m2;
        data_type_e    dt;
    } exp_t;

    // Legal encodings as lookup tables keyed by the distinguishing fields.
    alu_op_e    r_tab[int];
    alu_op_e    i_tab[int];
    alu_op_e    b_tab[int];
    data_type_e ld_tab[int];
    data_type_e st_tab[int];

    function automatic int rkey(input logic [4:0] o, input logic [6:0] f7, input logic [2:0] f3);
        return int'({17'd0, o, f7, f3});
    endfunction

    task automatic init_tables();
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd0)] = ALU_ADD;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd1)] = ALU_SLL;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd2)] = ALU_SLT;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd3)] = ALU_SLTU;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd4)] = ALU_XOR;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd5)] = ALU_SRL;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd6)] = ALU_OR;
        r_tab[rkey(OPCODE_OP, 7'h00, 3'd7)] = ALU_AND;
        r_tab[rkey(OPCODE_OP, 7'h20, 3'd0)] = ALU_SUB;
        r_tab[rkey(OPCODE_OP, 7'h20, 3'd5)] = ALU_SRA;
        if (RV64) begin
            r_tab[rkey(OPCODE_OP32, 7'h00, 3'd0)] = ALU_ADDW;
            r_tab[rkey(OPCODE_OP32, 7'h20, 3'd0)] = ALU_SUBW;
            r_tab[rkey(OPCODE_OP32, 7'h00, 3'd1)] = ALU_SLLW;
            r_tab[rkey(OPCODE_OP32, 7'h00, 3'd5)] = ALU_SRLW;
            r_tab[rkey(OPCODE_OP32, 7'h20, 3'd5)] = ALU_SRAW;
        end
        i_tab[0] = ALU_ADD;  i_tab[2] = ALU_SLT; i_tab[3] = ALU_SLTU;
        i_tab[4] = ALU_XOR;  i_tab[6] = ALU_OR;  i_tab[7] = ALU_AND;
        b_tab[0] = ALU_SEQ;  b_tab[1] = ALU_SNE; b_tab[4] = ALU_SLT;
        b_tab[5] = ALU_SGE;  b_tab[6] = ALU_SLTU; b_tab[7] = ALU_SGEU;
        ld_tab[0] = DT_BYTE; ld_tab[1] = DT_HALF; ld_tab[2] = DT_WORD;
        ld_tab[4] = DT_UBYTE; ld_tab[5] = DT_UHALF;
        st_tab[0] = DT_BYTE; st_tab[1] = DT_HALF; st_tab[2] = DT_WORD;
        if (RV64) begin
            ld_tab[3] = DT_DWORD; ld_tab[6] = DT_UWORD; st_tab[3] = DT_DWORD;
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t   e;
        longint sw = longint'($signed(w));
        longint imm_i = sw >>> 20;
        longint imm_s = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
        longint imm_b = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11)
                      | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        longint imm_u = longint'($signed(w & 32'hFFFF_F000));
        longint imm_j = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12)
                      | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
        logic [4:0] opc = w[6:2];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int k = rkey(opc, f7, f3);
        e.ill = (w[1:0] != 2'b11);
        e.fmt = FMT_I; e.op = ALU_ADD; e.m1 = MUX1_REG; e.m2 = MUX2_IMM; e.dt = DT_DWORD;
        e.imm = 64'(imm_i);
        case (opc)
            OPCODE_OP, OPCODE_OP32: begin
                e.fmt = FMT_R; e.m2 = MUX2_REG; e.imm = 64'd0;
                if (r_tab.exists(k)) e.op = r_tab[k]; else e.ill = 1'b1;
            end
            OPCODE_OP_IMM: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = 64'(w[25:20]);
                    e.op = (f3 == 3'd1) ? ALU_SLL : ((w[31:26] == 6'h10) ? ALU_SRA : ALU_SRL);
                    if (!(w[31:26] == 6'h00 || (f3 == 3'd5 && w[31:26] == 6'h10))) e.ill = 1'b1;
                    if (!RV64 && w[25]) e.ill = 1'b1;
                end else begin
                    e.op = i_tab[int'(f3)];
                end
            end
            OPCODE_OP_IMM32: begin
                if (!RV64) e.ill = 1'b1;
                if (f3 == 3'd0) begin
                    e.op = ALU_ADDW;
                end else if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = 64'(w[24:20]);
                    e.op = (f3 == 3'd1) ? ALU_SLLW : ((f7 == 7'h20) ? ALU_SRAW : ALU_SRLW);
                    if (!(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20))) e.ill = 1'b1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            OPCODE_LOAD: if (ld_tab.exists(int'(f3))) e.dt = ld_tab[int'(f3)]; else e.ill = 1'b1;
            OPCODE_STORE: begin
                e.fmt = FMT_S; e.imm = 64'(imm_s);
                if (st_tab.exists(int'(f3))) e.dt = st_tab[int'(f3)]; else e.ill = 1'b1;
            end
            OPCODE_BRANCH: begin
                e.fmt = FMT_B; e.m2 = MUX2_REG; e.imm = 64'(imm_b);
                if (b_tab.exists(int'(f3))) e.op = b_tab[int'(f3)]; else e.ill = 1'b1;
            end
            OPCODE_JAL:   begin e.fmt = FMT_J; e.m1 = MUX1_PC;  e.imm = 64'(imm_j); end
            OPCODE_JALR:  if (f3 != 3'd0) e.ill = 1'b1;
            OPCODE_LUI:   begin e.fmt = FMT_U; e.m1 = MUX1_IMM; e.imm = 64'(imm_u); end
            OPCODE_AUIPC: begin e.fmt = FMT_U; e.m1 = MUX1_PC;  e.imm = 64'(imm_u); end
            default: e.ill = 1'b1;
        endcase
        e.ra1 = (e.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? w[19:15] : 5'd0;
        e.ra2 = (e.fmt inside {FMT_R, FMT_S, FMT_B}) ? w[24:20] : 5'd0;
        e.wa  = (!e.ill && (e.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J})) ? w[11:7] : 5'd0;
        return e;
    endfunction

    task automatic check_model(input logic [31:0] w);
        exp_t e = model(w);
        chk($sformatf("illegal@%h", w), 64'(o_illegal_instr), 64'(e.ill));
        chk($sformatf("waddr@%h", w), 64'(o_rf_waddr), 64'(e.wa));
        if (!e.ill) begin
            chk($sformatf("raddr1@%h", w), 64'(o_rf_raddr1), 64'(e.ra1));
            chk($sformatf("raddr2@%h", w), 64'(o_rf_raddr2), 64'(e.ra2));
            chk($sformatf("imm@%h", w), o_imm, e.imm);
            chk($sformatf("format@%h", w), 64'(o_instr_format), 64'(e.fmt));
            chk($sformatf("alu_op@%h", w), 64'(o_alu_op), 64'(e.op));
            chk($sformatf("mux1@%h", w), 64'(o_alu_mux1_sel), 64'(e.m1));
            chk($sformatf("mux2@%h", w), 64'(o_alu_mux2_sel), 64'(e.m2));
            chk($sformatf("dtype@%h", w), 64'(o_data_type), 64'(e.dt));
        end
    endtask

    task automatic check_nop(input string tag);
        chk({tag, "_illegal"}, 64'(o_illegal_instr), 64'd0);
        chk({tag, "_raddr1"}, 64'(o_rf_raddr1), 64'd0);
        chk({tag, "_raddr2"}, 64'(o_rf_raddr2), 64'd0);
        chk({tag, "_waddr"}, 64'(o_rf_waddr), 64'd0);
        chk({tag, "_imm"}, o_imm, 64'd0);
        chk({tag, "_format"}, 64'(o_instr_format), 64'(FMT_I));
        chk({tag, "_alu_op"}, 64'(o_alu_op), 64'(ALU_ADD));
        chk({tag, "_mux1"}, 64'(o_alu_mux1_sel), 64'(MUX1_REG));
        chk({tag, "_mux2"}, 64'(o_alu_mux2_sel), 64'(MUX2_IMM));
        chk({tag, "_dtype"}, 64'(o_data_type), 64'(DT_DWORD));
    endtask

    task automatic drive(input logic [31:0] w);
        @(negedge i_clk);
        i_instr = w;
        @(posedge i_clk);
        #1;
    endtask

    logic [4:0] opc_list [11] = '{OPCODE_OP, OPCODE_OP32, OPCODE_OP_IMM, OPCODE_OP_IMM32,
                                  OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL,
                                  OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC};

    initial begin
        logic [31:0] w;
        init_tables();
        i_rst   = 1'b1;
        i_instr = 32'h407302B3;
        @(posedge i_clk);
        #1;
        check_nop("reset");

        @(negedge i_clk);
        i_rst = 1'b0;
        drive(32'h00300093);
        chk("addi_illegal", 64'(o_illegal_instr), 64'd0);
        chk("addi_waddr", 64'(o_rf_waddr), 64'd1);
        chk("addi_imm", o_imm, 64'd3);
        chk("addi_format", 64'(o_instr_format), 64'(FMT_I));
        check_model(32'h00300093);

        drive(32'h407302B3);
        chk("sub_raddr1", 64'(o_rf_raddr1), 64'd6);
        chk("sub_raddr2", 64'(o_rf_raddr2), 64'd7);
        chk("sub_waddr", 64'(o_rf_waddr), 64'd5);
        chk("sub_alu_op", 64'(o_alu_op), 64'(ALU_SUB));
        chk("sub_imm", o_imm, 64'd0);

        drive(32'hFE208EE3);
        chk("beq_waddr", 64'(o_rf_waddr), 64'd0);
        chk("beq_alu_op", 64'(o_alu_op), 64'(ALU_SEQ));
        chk("beq_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check_model(32'hFE208EE3);

        drive(32'h80000537);
        chk("lui_waddr", 64'(o_rf_waddr), 64'd10);
        chk("lui_mux1", 64'(o_alu_mux1_sel), 64'(MUX1_IMM));
        chk("lui_imm", o_imm, 64'hFFFF_FFFF_8000_0000);

        drive(32'h00007083);
        chk("ld7_illegal", 64'(o_illegal_instr), 64'd1);
        chk("ld7_waddr", 64'(o_rf_waddr), 64'd0);
        drive(32'h00000000);
        chk("zero_illegal", 64'(o_illegal_instr), 64'd1);

        // Reset mid-stream discards the instruction in flight.
        @(negedge i_clk);
        i_instr = 32'h407302B3;
        i_rst   = 1'b1;
        @(posedge i_clk);
        #1;
        check_nop("midrst");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check_model(32'h407302B3);
        chk("post_rst_alu_op", 64'(o_alu_op), 64'(ALU_SUB));

        for (int n = 0; n < 800; n++) begin
            int sel;
            w   = $urandom;
            sel = $urandom_range(0, 11);
            if (sel < 11) w[6:0] = {opc_list[sel], 2'b11};
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
            drive(w);
            check_model(w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ch0re_decoder.md
# ch0re_decoder

Combinational RV64I instruction decoder with one registered output stage. It sits in the decode stage of the ch0re pipeline, between fetch and the register file / ALU operand muxes. It classifies each 32-bit instruction, extracts register addresses, builds the sign-extended 64-bit immediate and selects the ALU operation, operand sources and memory data type. It flags any encoding outside the supported set as illegal.

## Interface
- No parameters.
- i_clk  in  1  clock; all outputs update on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_instr  in  32  raw instruction word.
- o_illegal_instr  out  1  instruction is not a supported encoding.
- o_rf_raddr1  out  5  rs1 address.
- o_rf_raddr2  out  5  rs2 address.
- o_rf_waddr  out  5  rd address; 0 means no writeback.
- o_imm  out  64  sign-extended immediate.
- o_instr_format  out  iformat_e  one of R, I, S, B, U, J.
- o_alu_op  out  alu_op_e  ALU operation.
- o_alu_mux1_sel  out  alu_mux1_sel_e  operand A source: REG, PC, or IMM (forces zero).
- o_alu_mux2_sel  out  alu_mux2_sel_e  operand B source: REG or IMM.
- o_data_type  out  data_type_e  load/store width and sign: BYTE, HALF, WORD, DWORD, UBYTE, UHALF, UWORD.

## Operation
- **Field extraction:**
  - opcode = i_instr[6:2]; i_instr[1:0] must equal 2'b11.
  - rd = i_instr[11:7], funct3 = i_instr[14:12], rs1 = i_instr[19:15], rs2 = i_instr[24:20], funct7 = i_instr[31:25].
- **Register addresses:**
  - raddr1 = rs1 for R, I, S and B formats; 0 otherwise.
  - raddr2 = rs2 for R, S and B formats; 0 otherwise.
  - waddr = rd for R, I, U and J formats; 0 for S and B formats and for any illegal instruction.
- **OP** (R format, mux1 REG, mux2 REG):
  - funct7 = 0x00: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 = 0x20: SUB (funct3 0) and SRA (funct3 5).
  - All other funct7/funct3 combinations are illegal.
- **OP32** (R format): ADDW, SUBW, SLLW, SRLW, SRAW. Any other funct7/funct3 combination is illegal.
- **OP_IMM** (I format, mux1 REG, mux2 IMM):
  - ADDI, XORI, ORI, ANDI, SLTI and SLTIU use imm = sext(i_instr[31:20]).
  - SLLI, SRLI and SRAI use imm = zext(i_instr[25:20]). i_instr[31:26] must be 6'h00, or 6'h10 for SRAI; any other value is illegal.
- **OP_IMM32** (I format):
  - ADDIW uses the normal I immediate.
  - SLLIW, SRLIW and SRAIW use imm = zext(i_instr[24:20]). i_instr[25] must be 0 and funct7 must be 0x00 or 0x20 (0x20 only for SRAIW); otherwise illegal.
- **LOAD** (I format, ALU ADD, REG + IMM):
  - funct3 0–6 map to data_type BYTE, HALF, WORD, DWORD, UBYTE, UHALF, UWORD.
  - funct3 7 is illegal.
- **JALR**: I format, ADD, REG + IMM. funct3 ≠ 0 is illegal.
- **STORE** (S format, ADD, REG + IMM):
  - imm = sext({i_instr[31:25], i_instr[11:7]}).
  - funct3 0–3 map to BYTE, HALF, WORD, DWORD; funct3 > 3 is illegal.
- **BRANCH** (B format, mux1 REG, mux2 REG):
  - imm = sext({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}).
  - funct3 0, 1, 4, 5, 6, 7 map to alu_op SEQ, SNE, SLT, SGE, SLTU, SGEU; funct3 2 and 3 are illegal.
- **JAL**: J format, ADD, PC + IMM. imm = sext({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}).
- **LUI**: U format, ADD, mux1 IMM (zero), mux2 IMM. imm = sext({i_instr[31:12], 12'b0}).
- **AUIPC**: as LUI but mux1 is PC.
- **Defaults:**
  - R-format imm = 0.
  - data_type = DWORD for every non-memory instruction.
  - Any other opcode is illegal.
- **Illegal instructions:** o_illegal_instr = 1 and waddr = 0. All other outputs are decoded as far as possible; their values are don't-care to consumers.

## Timing
- Outputs are registered: an instruction presented on cycle N is decoded on the outputs from the rising edge ending cycle N.
- Latency is 1 cycle, throughput is 1 instruction per cycle, with no handshake or stall.
- Reset wins over any input. Reset values are the decode of a NOP (addi x0,x0,0):
  - illegal 0, raddr1/raddr2/waddr 0, imm 0.
  - format I, ADD, mux1 REG, mux2 IMM, data_type DWORD.
- Reset asserted mid-stream discards the instruction in flight. The first instruction after reset deasserts appears one cycle later.

## Configuration
- CH0RE_RV64_EN defined: full RV64I decoding as above.
- Not defined (RV32I):
  - OP32, OP_IMM32, LD, LWU and SD are illegal.
  - Shift-immediate encodings require i_instr[25] = 0.
  - Immediates are still sign-extended to 64 bits.

## Structure
- Package ch0re_types holds:
  - 5-bit opcode constants: OPCODE_OP, OP32, OP_IMM, OP_IMM32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Enums iformat_e, alu_op_e, alu_mux1_sel_e, alu_mux2_sel_e, data_type_e.
- One sub-module, ch0re_imm_gen, maps instruction + format to the 64-bit immediate.

## Test plan
- 0x00300093 (addi x1,x0,3) → illegal 0, raddr1 0, waddr 1, imm 3, I format, ADD, REG/IMM, DWORD.
- 0x407302B3 (sub x5,x6,x7) → raddr1 6, raddr2 7, waddr 5, R format, SUB, REG/REG, imm 0.
- 0xFE208EE3 (beq x1,x2,-4) → raddr1 1, raddr2 2, waddr 0, B format, SEQ, REG/REG, imm 0xFFFF_FFFF_FFFF_FFFC.
- 0x80000537 (lui x10,0x80000) → waddr 10, U format, mux1 IMM, mux2 IMM, imm 0xFFFF_FFFF_8000_0000.
- 0x00007083 (load funct3 7) → illegal 1, waddr 0. Also 0x00000000 → illegal 1.
- Assert i_rst while 0x407302B3 is presented → next-edge outputs equal the NOP reset values. After deassert, the decode appears one cycle later.
